// File: rtl/truth_table_pkg.sv
// truth_table_pkg: shared definitions for the programmable truth-table block.
//   DEFAULT_TABLE_INIT : reset contents for N_IN=4, N_OUT=1 (Y = ~A & ~D, A = MSB)
//   state_e            : sweep FSM encoding (ST_IDLE, ST_SWEEP)
//   depth_of()         : number of table rows for a given input count
package truth_table_pkg;

    localparam logic [15:0] DEFAULT_TABLE_INIT = 16'h0055;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    function automatic int depth_of(input int n_in);
        return 1 << n_in;
    endfunction

endpackage

// File: rtl/truth_table_mem.sv
// truth_table_mem: reset-initialised row storage for truth_table_unit.
// One synchronous write port, two asynchronous read ports.
//   clk, rst_n             : clock, asynchronous active-low reset (loads TABLE_INIT)
//   wr_en/wr_addr/wr_data  : row write, takes effect from the sampling edge onward
//   rd_a_addr -> rd_a_data : lookup read port
//   rd_b_addr -> rd_b_data : sweep read port
module truth_table_mem
    import truth_table_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter logic [depth_of(N_IN)*N_OUT-1:0] TABLE_INIT = DEFAULT_TABLE_INIT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [N_IN-1:0]  wr_addr,
    input  logic [N_OUT-1:0] wr_data,
    input  logic [N_IN-1:0]  rd_a_addr,
    output logic [N_OUT-1:0] rd_a_data,
    input  logic [N_IN-1:0]  rd_b_addr,
    output logic [N_OUT-1:0] rd_b_data
);

    localparam int DEPTH = depth_of(N_IN);

    logic [N_OUT-1:0] rows [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < DEPTH; r++) begin
                rows[r] <= TABLE_INIT[r*N_OUT +: N_OUT];
            end
        end else if (wr_en) begin
            rows[wr_addr] <= wr_data;
        end
    end

    assign rd_a_data = rows[rd_a_addr];
    assign rd_b_data = rows[rd_b_addr];

endmodule

// File: rtl/truth_table_unit.sv
// truth_table_unit: run-time programmable 2^N_IN-row truth table with
// registered single-shot lookups and a full-table sweep stream.
//   i_clk, i_rst_n             : clock, asynchronous active-low reset
//   i_wr_en/i_wr_addr/i_wr_data: row write (ignored while o_busy)
//   i_valid/i_in -> o_valid/o_y: 1-cycle lookup, no backpressure (ignored while o_busy)
//   i_sweep_start, o_busy      : start a sweep (pulse), sweep in progress
//   o_sweep_valid/i_sweep_ready/o_sweep_addr/o_sweep_y/o_sweep_last : sweep stream
// Optional (macro TRUTH_TABLE_ONES_COUNT_EN):
//   o_ones_count, o_count_valid: number of rows with bit 0 set, pulsed after a sweep
//
// Sweep handshake: a beat transfers on every rising edge where o_sweep_valid and
// i_sweep_ready are both 1; addr/y/last stay stable until that edge, and
// o_sweep_valid never drops before the last row has transferred.
module truth_table_unit
    import truth_table_pkg::*;
#(
    parameter int N_IN  = 4,
    parameter int N_OUT = 1,
    parameter logic [depth_of(N_IN)*N_OUT-1:0] TABLE_INIT = DEFAULT_TABLE_INIT
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_wr_en,
    input  logic [N_IN-1:0]  i_wr_addr,
    input  logic [N_OUT-1:0] i_wr_data,
    input  logic             i_valid,
    input  logic [N_IN-1:0]  i_in,
    output logic             o_valid,
    output logic [N_OUT-1:0] o_y,
    input  logic             i_sweep_start,
    output logic             o_busy,
    output logic             o_sweep_valid,
    input  logic             i_sweep_ready,
    output logic [N_IN-1:0]  o_sweep_addr,
    output logic [N_OUT-1:0] o_sweep_y,
    output logic             o_sweep_last
`ifdef TRUTH_TABLE_ONES_COUNT_EN
    ,
    output logic [N_IN:0]    o_ones_count,
    output logic             o_count_valid
`endif
);

    localparam logic [0:0]      IDLE      = ST_IDLE;
    localparam logic [0:0]      SWEEP     = ST_SWEEP;
    localparam logic [N_IN-1:0] LAST_ADDR = N_IN'(depth_of(N_IN) - 1);

    logic [0:0]       state;
    logic             busy;
    logic             wr_ok;
    logic             lookup_ok;
    logic             xfer;
    logic             at_last;
    logic [N_OUT-1:0] lookup_row;
    logic [N_OUT-1:0] sweep_row;

    assign busy      = (state == SWEEP);
    assign wr_ok     = i_wr_en & ~busy;
    assign lookup_ok = i_valid & ~busy;
    assign xfer      = o_sweep_valid & i_sweep_ready;
    assign at_last   = (o_sweep_addr == LAST_ADDR);

    truth_table_mem #(
        .N_IN       (N_IN),
        .N_OUT      (N_OUT),
        .TABLE_INIT (TABLE_INIT)
    ) u_mem (
        .clk       (i_clk),
        .rst_n     (i_rst_n),
        .wr_en     (wr_ok),
        .wr_addr   (i_wr_addr),
        .wr_data   (i_wr_data),
        .rd_a_addr (i_in),
        .rd_a_data (lookup_row),
        .rd_b_addr (o_sweep_addr),
        .rd_b_data (sweep_row)
    );

    // Registered lookup: the array is read before the edge's write lands,
    // so a same-edge write/lookup to one row returns the old contents.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= 1'b0;
            o_y     <= '0;
        end else begin
            o_valid <= lookup_ok;
            if (lookup_ok) begin
                o_y <= lookup_row;
            end
        end
    end

    // Sweep FSM. The row value is read combinationally from the current
    // address; the table is write-locked while busy, so it cannot change
    // under a stalled beat, and a write on the start edge is already visible.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state         <= IDLE;
            o_sweep_valid <= 1'b0;
            o_sweep_addr  <= '0;
        end else if (state == IDLE) begin
            if (i_sweep_start) begin
                state         <= SWEEP;
                o_sweep_valid <= 1'b1;
                o_sweep_addr  <= '0;
            end
        end else if (xfer) begin
            if (at_last) begin
                state         <= IDLE;
                o_sweep_valid <= 1'b0;
                o_sweep_addr  <= '0;
            end else begin
                o_sweep_addr <= o_sweep_addr + N_IN'(1);
            end
        end
    end

    assign o_busy       = busy;
    assign o_sweep_y    = o_sweep_valid ? sweep_row : '0;
    assign o_sweep_last = o_sweep_valid & at_last;

`ifdef TRUTH_TABLE_ONES_COUNT_EN
    localparam int CW = N_IN + 1;

    // The count register is the output; it holds its final value once the
    // last beat has transferred, and o_count_valid flags that cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_ones_count  <= '0;
            o_count_valid <= 1'b0;
        end else begin
            o_count_valid <= 1'b0;
            if (state == IDLE && i_sweep_start) begin
                o_ones_count <= '0;
            end else if (xfer) begin
                o_ones_count <= o_ones_count + CW'(o_sweep_y[0]);
                if (at_last) begin
                    o_count_valid <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_truth_table_unit.sv
module tb_truth_table_unit;

    localparam int N_IN  = 4;
    localparam int N_OUT = 1;
    localparam int DEPTH = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_wr_en = 1'b0;
    logic [N_IN-1:0]  i_wr_addr = '0;
    logic [N_OUT-1:0] i_wr_data = '0;
    logic             i_valid = 1'b0;
    logic [N_IN-1:0]  i_in = '0;
    logic             o_valid;
    logic [N_OUT-1:0] o_y;
    logic             i_sweep_start = 1'b0;
    logic             o_busy;
    logic             o_sweep_valid;
    logic             i_sweep_ready = 1'b0;
    logic [N_IN-1:0]  o_sweep_addr;
    logic [N_OUT-1:0] o_sweep_y;
    logic             o_sweep_last;
`ifdef TRUTH_TABLE_ONES_COUNT_EN
    logic [N_IN:0]    o_ones_count;
    logic             o_count_valid;
    int               count_pulses = 0;
`endif

    truth_table_unit #(.N_IN(N_IN), .N_OUT(N_OUT)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .i_valid       (i_valid),
        .i_in          (i_in),
        .o_valid       (o_valid),
        .o_y           (o_y),
        .i_sweep_start (i_sweep_start),
        .o_busy        (o_busy),
        .o_sweep_valid (o_sweep_valid),
        .i_sweep_ready (i_sweep_ready),
        .o_sweep_addr  (o_sweep_addr),
        .o_sweep_y     (o_sweep_y),
        .o_sweep_last  (o_sweep_last)
`ifdef TRUTH_TABLE_ONES_COUNT_EN
        ,
        .o_ones_count  (o_ones_count),
        .o_count_valid (o_count_valid)
`endif
    );

    // ---------------- clock / reset bookkeeping ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // ---------------- reference model + scoreboard ----------------
    logic [15:0]      init_bits = 16'h0055;
    logic [N_OUT-1:0] model [DEPTH];
    logic [N_OUT-1:0] exp_q[$];
    int               exp_cyc_q[$];
    logic [5:0]       sw_q[$];
    int               exp_ones = 0;

    task automatic model_reset();
        for (int r = 0; r < DEPTH; r++) model[r] = init_bits[r];
    endtask

    // Lookup monitor: one o_valid per accepted request, exactly one cycle later.
    logic [N_OUT-1:0] lk_exp;
    int               lk_cyc;
    always @(negedge clk) begin
        if (rst_n) begin
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] < cyc) begin
                check_eq("lookup_missing", 32'(o_valid), 32'd1);
                void'(exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end
            if (o_valid) begin
                if (exp_q.size() == 0) begin
                    check_eq("lookup_unexpected", 32'(o_valid), 32'd0);
                end else begin
                    lk_exp = exp_q.pop_front();
                    lk_cyc = exp_cyc_q.pop_front();
                    check_eq("lookup_y", 32'(o_y), 32'(lk_exp));
                    check_eq("lookup_latency", 32'(cyc), 32'(lk_cyc));
                end
            end
        end
    end

    // Sweep monitor: compares each transferred beat and holds during stalls.
    logic [5:0] cur_beat, prev_beat, exp_beat;
    logic       prev_stall = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else if (o_sweep_valid) begin
            cur_beat = {o_sweep_addr, o_sweep_y, o_sweep_last};
            if (prev_stall) check_eq("sweep_hold", 32'(cur_beat), 32'(prev_beat));
            if (i_sweep_ready) begin
                prev_stall = 1'b0;
                if (sw_q.size() == 0) begin
                    check_eq("sweep_extra_beat", 32'(cur_beat), 32'h3f);
                end else begin
                    exp_beat = sw_q.pop_front();
                    check_eq("sweep_beat", 32'(cur_beat), 32'(exp_beat));
                end
            end else begin
                prev_stall = 1'b1;
                prev_beat  = cur_beat;
            end
        end else begin
            prev_stall = 1'b0;
            check_eq("sweep_idle_last", 32'(o_sweep_last), 32'd0);
        end
    end

`ifdef TRUTH_TABLE_ONES_COUNT_EN
    always @(negedge clk) begin
        if (rst_n && o_count_valid) begin
            count_pulses++;
            check_eq("ones_count", 32'(o_ones_count), 32'(exp_ones));
        end
    end
`endif

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic do_lookup(input logic [N_IN-1:0] a);
        i_valid = 1'b1;
        i_in    = a;
        exp_q.push_back(model[a]);
        exp_cyc_q.push_back(cyc + 1);
        @(posedge clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic do_write(input logic [N_IN-1:0] a, input logic [N_OUT-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        model[a]  = d;
        @(posedge clk); #1;
        i_wr_en = 1'b0;
    endtask

    // Same-edge write and lookup of one row: the lookup sees the old value.
    task automatic do_write_lookup(input logic [N_IN-1:0] a, input logic [N_OUT-1:0] d);
        i_valid = 1'b1;
        i_in    = a;
        exp_q.push_back(model[a]);
        exp_cyc_q.push_back(cyc + 1);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_data = d;
        model[a]  = d;
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_wr_en = 1'b0;
    endtask

    function automatic logic ready_pat(input logic toggle, input int k);
        return !toggle || (k % 4 == 0) || (k % 4 == 3);
    endfunction

    task automatic push_sweep();
        exp_ones = 0;
        for (int r = 0; r < DEPTH; r++) begin
            sw_q.push_back({4'(r), model[r], (r == DEPTH - 1)});
            exp_ones += int'(model[r][0]);
        end
    endtask

    // toggle: ready pattern 1,0,0,1; extras: write/lookup attempts while busy;
    // wr_same: a row write on the start edge.
    task automatic run_sweep(input logic toggle, input logic extras, input logic wr_same,
                             input logic [N_IN-1:0] wa, input logic [N_OUT-1:0] wd);
        logic done;
        int   k;
        i_sweep_start = 1'b1;
        if (wr_same) begin
            i_wr_en   = 1'b1;
            i_wr_addr = wa;
            i_wr_data = wd;
            model[wa] = wd;
        end
        push_sweep();
        @(posedge clk); #1;
        i_sweep_start = 1'b0;
        i_wr_en       = 1'b0;
        check_eq("busy_after_start", 32'(o_busy), 32'd1);
        done = 1'b0;
        k    = 0;
        for (int n = 0; n < 200; n++) begin
            if (sw_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            i_sweep_ready = ready_pat(toggle, k);
            if (extras) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 4'd5;
                i_wr_data = 1'b1;
                i_valid   = 1'b1;
                i_in      = 4'd0;
                i_sweep_start = (k % 3 == 0);
            end
            k++;
            @(posedge clk); #1;
        end
        i_sweep_ready = 1'b0;
        i_wr_en       = 1'b0;
        i_valid       = 1'b0;
        i_sweep_start = 1'b0;
        check_eq("sweep_complete", 32'(done), 32'd1);
        check_eq("busy_dropped", 32'(o_busy), 32'd0);
        check_eq("sweep_valid_dropped", 32'(o_sweep_valid), 32'd0);
        sw_q.delete();
        @(posedge clk); #1;
`ifdef TRUTH_TABLE_ONES_COUNT_EN
        check_eq("count_pulses", 32'(count_pulses), 32'd1);
        count_pulses = 0;
`endif
    endtask

    task automatic reset_mid_sweep();
        logic reached;
        do_write(4'd0, 1'b0);
        i_sweep_start = 1'b1;
        i_sweep_ready = 1'b1;
        push_sweep();
        @(posedge clk); #1;
        i_sweep_start = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < 50; n++) begin
            if (o_sweep_valid && o_sweep_addr == 4'd7) begin
                reached = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        check_eq("reached_beat7", 32'(reached), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_busy", 32'(o_busy), 32'd0);
        check_eq("rst_sweep_valid", 32'(o_sweep_valid), 32'd0);
        check_eq("rst_valid", 32'(o_valid), 32'd0);
        check_eq("rst_sweep_addr", 32'(o_sweep_addr), 32'd0);
        sw_q.delete();
        exp_q.delete();
        exp_cyc_q.delete();
        model_reset();
        i_sweep_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        do_lookup(4'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        model_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_valid", 32'(o_valid), 32'd0);
        check_eq("reset_y", 32'(o_y), 32'd0);
        check_eq("reset_busy", 32'(o_busy), 32'd0);
        check_eq("reset_sweep_valid", 32'(o_sweep_valid), 32'd0);
        check_eq("reset_sweep_addr", 32'(o_sweep_addr), 32'd0);
        check_eq("reset_sweep_y", 32'(o_sweep_y), 32'd0);
        check_eq("reset_sweep_last", 32'(o_sweep_last), 32'd0);
`ifdef TRUTH_TABLE_ONES_COUNT_EN
        check_eq("reset_ones_count", 32'(o_ones_count), 32'd0);
        check_eq("reset_count_valid", 32'(o_count_valid), 32'd0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Default-table lookups.
        do_lookup(4'b0000);
        do_lookup(4'b0001);
        do_lookup(4'b0110);
        do_lookup(4'b1000);

        // Full sweep, ready held high.
        run_sweep(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);

        // Writes, then lookups.
        do_write(4'b1111, 1'b1);
        do_lookup(4'b1111);
        do_write_lookup(4'd3, 1'b1);
        do_lookup(4'd3);

        // Stalling sweep with ignored writes/lookups/starts while busy.
        run_sweep(1'b1, 1'b1, 1'b0, 4'd0, 1'b0);
        do_lookup(4'd5);
        do_lookup(4'd0);

        // Start and write on the same edge: sweep sees the new row value.
        run_sweep(1'b0, 1'b0, 1'b1, 4'd1, 1'b1);

        // Random lookups against the model.
        for (int n = 0; n < 12; n++) begin
            do_lookup(4'($urandom_range(0, DEPTH - 1)));
        end

        reset_mid_sweep();

`ifdef TRUTH_TABLE_ONES_COUNT_EN
        model_reset();
        run_sweep(1'b0, 1'b0, 1'b0, 4'd0, 1'b0);
        for (int r = 0; r < DEPTH; r++) do_write(4'(r), 1'b1);
        run_sweep(1'b1, 1'b0, 1'b0, 4'd0, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check_eq("lookup_queue_drained", 32'(exp_q.size()), 32'd0);
        check_eq("sweep_queue_drained", 32'(sw_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/truth_table_unit.md
Name: truth_table_unit

Overview:
- Parametrised, run-time programmable truth-table block.
- Holds a 2^N_IN-row table of N_OUT-bit outputs, loaded row by row.
- Evaluates registered single-shot lookups and can sweep all rows out through a valid/ready stream, regenerating the full logic table for lab checking.
- Sits between the lab input switches/stimulus driver and the result display/UART dumper.

Parameters:
- N_IN, 4, number of logic inputs; table depth is 2^N_IN, legal range 1..8.
- N_OUT, 1, number of output functions per row, legal range 1..8.
- TABLE_INIT, 16'h0055, reset contents; row r occupies bits [r*N_OUT +: N_OUT]; width is (2^N_IN)*N_OUT. The default is Y=1 on rows 0,2,4,6, i.e. Y = ~A & ~D with A as the MSB.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_wr_en  in  1  write one table row
- i_wr_addr  in  N_IN  row index, {A,B,C,D...} with A as MSB
- i_wr_data  in  N_OUT  row value
- i_valid  in  1  lookup request
- i_in  in  N_IN  lookup input vector
- o_valid  out  1  lookup result valid
- o_y  out  N_OUT  lookup result
- i_sweep_start  in  1  start full-table sweep (pulse)
- o_busy  out  1  sweep in progress
- o_sweep_valid  out  1  sweep row valid
- i_sweep_ready  in  1  consumer accepts sweep row
- o_sweep_addr  out  N_IN  row index of current sweep beat
- o_sweep_y  out  N_OUT  row value of current sweep beat
- o_sweep_last  out  1  current beat is row 2^N_IN-1

Behaviour:
- Clocking and reset:
  - Single clock domain; reset is asynchronous and active-low.
  - Reset loads the table with TABLE_INIT.
  - All outputs reset to 0; FSM resets to IDLE.
- Write:
  - i_wr_en sampled at a rising edge updates the row from that edge onward.
  - A write is ignored while o_busy=1, so the table is locked during a sweep.
- Lookup:
  - Latency is 1 cycle. When i_valid=1 at edge t, then at t+1 o_valid=1 and o_y=table[i_in].
  - o_valid is a one-cycle pulse per request, with no backpressure.
  - Write and lookup to the same row on the same edge returns the OLD value.
  - i_valid is ignored while o_busy=1; o_valid stays 0 during the sweep.
- FSM states are IDLE and SWEEP.
- IDLE:
  - On i_sweep_start=1, go to SWEEP.
  - Set o_busy=1, o_sweep_valid=1, o_sweep_addr=0, o_sweep_y=table[0].
- SWEEP:
  - A beat transfers on an edge where o_sweep_valid & i_sweep_ready.
  - Until transfer, addr, y and last are held stable.
  - On a transfer of a non-last row, addr increments and y is reloaded.
  - On a transfer of the last row, return to IDLE and drop o_busy and o_sweep_valid.
- o_sweep_last = o_sweep_valid & (o_sweep_addr == 2^N_IN-1).
- Start while busy is ignored.
- If start and write arrive on the same edge in IDLE, the write lands first and the sweep reads the new value.
- Sweep address counter is N_IN+0 bits with wrap detected by compare, with no overflow beyond the last row.
- N_IN=1 gives a 2-beat sweep; both beats must honour ready.
- Reset mid-sweep returns to IDLE immediately and restores TABLE_INIT.

Optional Feature:
- Macro: TRUTH_TABLE_ONES_COUNT_EN.
- With the macro defined:
  - Add output o_ones_count (N_IN+1 bits, reset 0) and o_count_valid (1 bit, reset 0).
  - A counter clears at sweep start and adds bit 0 of o_sweep_y on each transfer.
  - On the cycle after the last transfer, o_count_valid pulses for 1 cycle with the final minterm count.
  - Default table gives count 4.
- Without the macro: neither port exists and there is no counter logic.

Decomposition:
- Package truth_table_pkg holds:
  - localparam functions for DEPTH = 2**N_IN;
  - the state enum typedef (IDLE, SWEEP);
  - the default TABLE_INIT constant.
- One natural sub-module, truth_table_mem: reset-initialised register array with one write port and two asynchronous read ports (lookup, sweep).
- The FSM and handshake stay in the top module.

Test Plan:
- Reset with default params, then lookup i_in=4'b0000,0001,0110,1000 → o_y=1,0,1,0, each with o_valid exactly 1 cycle later.
- Write row 4'b1111=1, then lookup 4'b1111 on the next cycle → o_y=1. Write and lookup row 3 on the same edge → old value 0.
- Sweep with i_sweep_ready held 1 → 16 consecutive beats with addr 0..15 and y pattern 1010101000000000; o_sweep_last only on addr 15; o_busy falls next cycle.
- Sweep with ready toggling 1,0,0,1 repeatedly → addr/y stable while stalled, no rows lost or repeated. Writes and lookups during the sweep are ignored (o_valid=0, table unchanged afterward).
- Assert i_rst_n=0 at beat 7 of a sweep after writing row 0=0 → o_busy, o_sweep_valid and o_valid are 0 at once; row 0 reads back 1 afterward.
- With TRUTH_TABLE_ONES_COUNT_EN: default sweep → o_ones_count=4 with a single o_count_valid pulse; after writing all rows=1 → o_ones_count=16.
